// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory arbiter slice: default widths, the
// request payload record and small width helpers used to size pointers
// and counters.
// No ports (package).
package mem_arb_pkg;

  localparam int ARB_ADDR_W    = 32;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_BE_W      = ARB_DATA_W / 8;
  localparam int ARB_NUM_CH    = 2;
  localparam int ARB_MAX_OUTST = 4;

  // Request payload as seen on the downstream memory port.
  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] data;
    logic [ARB_BE_W-1:0]   byte_lane;
    logic                  is_write;
  } mem_req_t;

  // Width needed to index n items (never less than one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int ARB_CH_W  = idx_w(ARB_NUM_CH);
  localparam int ARB_CNT_W = cnt_w(ARB_MAX_OUTST);

endpackage

// File: rtl/id_fifo.sv
// id_fifo
// Small synchronous FIFO holding the channel IDs of accepted requests in
// acceptance order, so in-order memory responses can be routed back.
// Ports:
//   clock, reset         - clock, synchronous active-high reset
//   push, push_data      - write an entry (ignored when full)
//   pop,  pop_data       - remove the head (ignored when empty); pop_data
//                          always shows the current head
//   full, empty, count   - occupancy status
module id_fifo
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [cnt_w(DEPTH)-1:0] count
);

  localparam int PTR_W = idx_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == {CNT_W{1'b0}});
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];
  assign count    = cnt;

  // Entry storage; contents need no reset because count gates their use.
  always_ff @(posedge clock) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      cnt    <= {CNT_W{1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin arbiter sharing one downstream memory port among NUM_CH
// requesters. Accepted channel IDs are queued so in-order memory responses
// are steered back to the right requester with no added latency.
// Ports:
//   clock, reset                 - clock, synchronous active-high reset
//   io_req_valid / io_req_ready  - per-channel handshake
//   io_req_bits_*                - per-channel payload, channel c at slice c
//   io_rsp_valid, io_rsp_bits_*  - per-channel response strobe, shared data
//   io_mem_req_*                 - downstream request (granted channel)
//   io_mem_rsp_*                 - downstream in-order response
//   io_outstanding               - accepted-but-unanswered count
//   io_err_unexpected_rsp        - sticky: response arrived with none pending
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH    = ARB_NUM_CH,
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_OUTST = ARB_MAX_OUTST
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            io_req_valid,
  output logic [NUM_CH-1:0]            io_req_ready,
  input  logic [NUM_CH*ADDR_W-1:0]     io_req_bits_addrRequest,
  input  logic [NUM_CH*DATA_W-1:0]     io_req_bits_dataRequest,
  input  logic [NUM_CH*(DATA_W/8)-1:0] io_req_bits_activeByteLane,
  input  logic [NUM_CH-1:0]            io_req_bits_isWrite,
  output logic [NUM_CH-1:0]            io_rsp_valid,
  output logic [DATA_W-1:0]            io_rsp_bits_dataResponse,
  output logic                         io_mem_req_valid,
  output logic [ADDR_W-1:0]            io_mem_req_bits_addrRequest,
  output logic [DATA_W-1:0]            io_mem_req_bits_dataRequest,
  output logic [DATA_W/8-1:0]          io_mem_req_bits_activeByteLane,
  output logic                         io_mem_req_bits_isWrite,
  input  logic                         io_mem_req_ready,
  input  logic                         io_mem_rsp_valid,
  input  logic [DATA_W-1:0]            io_mem_rsp_bits_dataResponse,
  output logic [cnt_w(MAX_OUTST)-1:0]  io_outstanding,
  output logic                         io_err_unexpected_rsp
);

  localparam int CH_W  = idx_w(NUM_CH);
  localparam int CNT_W = cnt_w(MAX_OUTST);
  localparam int BE_W  = DATA_W / 8;

  logic [CH_W-1:0]   ptr;
  logic              locked;
  logic [CH_W-1:0]   lock_ch;
  logic              err;
  logic [CH_W-1:0]   rr_grant;
  logic              rr_found;
  logic [CH_W-1:0]   grant;
  logic              lock_hold;
  logic              req_valid;
  logic              accept;
  logic              rsp_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CH_W-1:0]   fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic [NUM_CH-1:0] one_hot_lsb;

  assign one_hot_lsb = {{(NUM_CH-1){1'b0}}, 1'b1};

  // Round-robin search: first valid channel at or after the pointer, wrapping.
  always_comb begin
    logic [CH_W-1:0] idx;
    rr_grant = ptr;
    rr_found = 1'b0;
    idx      = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!rr_found && io_req_valid[idx]) begin
        rr_grant = idx;
        rr_found = 1'b1;
      end else begin
        rr_found = rr_found;
      end
    end
  end

  // A stalled grant stays on its channel only while that channel keeps valid.
  assign lock_hold = locked && io_req_valid[lock_ch];
  assign grant     = lock_hold ? lock_ch : rr_grant;

  assign req_valid        = (|io_req_valid) && !fifo_full && !reset;
  assign accept           = req_valid && io_mem_req_ready;
  assign rsp_pop          = io_mem_rsp_valid && !fifo_empty && !reset;

  assign io_mem_req_valid               = req_valid;
  assign io_mem_req_bits_addrRequest    = io_req_bits_addrRequest[int'(grant)*ADDR_W +: ADDR_W];
  assign io_mem_req_bits_dataRequest    = io_req_bits_dataRequest[int'(grant)*DATA_W +: DATA_W];
  assign io_mem_req_bits_activeByteLane = io_req_bits_activeByteLane[int'(grant)*BE_W +: BE_W];
  assign io_mem_req_bits_isWrite        = io_req_bits_isWrite[grant];

  assign io_req_ready             = accept ? (one_hot_lsb << grant) : {NUM_CH{1'b0}};
  assign io_rsp_valid             = rsp_pop ? (one_hot_lsb << fifo_head) : {NUM_CH{1'b0}};
  assign io_rsp_bits_dataResponse = io_mem_rsp_bits_dataResponse;
  assign io_outstanding           = fifo_count;
  assign io_err_unexpected_rsp    = err;

  id_fifo #(
    .WIDTH (CH_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (accept),
    .push_data (grant),
    .pop       (rsp_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Priority pointer, stall lock and sticky unexpected-response flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr     <= {CH_W{1'b0}};
      locked  <= 1'b0;
      lock_ch <= {CH_W{1'b0}};
      err     <= 1'b0;
    end else begin
      if (accept) begin
        ptr <= (grant == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : grant + CH_W'(1);
      end else begin
        ptr <= ptr;
      end
      if (req_valid && !io_mem_req_ready) begin
        locked  <= 1'b1;
        lock_ch <= grant;
      end else begin
        locked  <= 1'b0;
        lock_ch <= lock_ch;
      end
      // An empty queue means the response belongs to nobody, even if a push lands this cycle.
      if (io_mem_rsp_valid && fifo_empty) begin
        err <= 1'b1;
      end else begin
        err <= err;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter (NUM_CH=2, MAX_OUTST=4, 32-bit data).
// Inputs are driven #1 after the rising edge, outputs sampled #1 later.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  io_req_valid;
  logic [1:0]  io_req_ready;
  logic [63:0] io_req_bits_addrRequest;
  logic [63:0] io_req_bits_dataRequest;
  logic [7:0]  io_req_bits_activeByteLane;
  logic [1:0]  io_req_bits_isWrite;
  logic [1:0]  io_rsp_valid;
  logic [31:0] io_rsp_bits_dataResponse;
  logic        io_mem_req_valid;
  logic [31:0] io_mem_req_bits_addrRequest;
  logic [31:0] io_mem_req_bits_dataRequest;
  logic [3:0]  io_mem_req_bits_activeByteLane;
  logic        io_mem_req_bits_isWrite;
  logic        io_mem_req_ready;
  logic        io_mem_rsp_valid;
  logic [31:0] io_mem_rsp_bits_dataResponse;
  logic [2:0]  io_outstanding;
  logic        io_err_unexpected_rsp;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .NUM_CH    (2),
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_OUTST (4)
  ) dut (
    .clock                          (clock),
    .reset                          (reset),
    .io_req_valid                   (io_req_valid),
    .io_req_ready                   (io_req_ready),
    .io_req_bits_addrRequest        (io_req_bits_addrRequest),
    .io_req_bits_dataRequest        (io_req_bits_dataRequest),
    .io_req_bits_activeByteLane     (io_req_bits_activeByteLane),
    .io_req_bits_isWrite            (io_req_bits_isWrite),
    .io_rsp_valid                   (io_rsp_valid),
    .io_rsp_bits_dataResponse       (io_rsp_bits_dataResponse),
    .io_mem_req_valid               (io_mem_req_valid),
    .io_mem_req_bits_addrRequest    (io_mem_req_bits_addrRequest),
    .io_mem_req_bits_dataRequest    (io_mem_req_bits_dataRequest),
    .io_mem_req_bits_activeByteLane (io_mem_req_bits_activeByteLane),
    .io_mem_req_bits_isWrite        (io_mem_req_bits_isWrite),
    .io_mem_req_ready               (io_mem_req_ready),
    .io_mem_rsp_valid               (io_mem_rsp_valid),
    .io_mem_rsp_bits_dataResponse   (io_mem_rsp_bits_dataResponse),
    .io_outstanding                 (io_outstanding),
    .io_err_unexpected_rsp          (io_err_unexpected_rsp)
  );

  // Free-running 10-unit clock.
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic mrdy, input logic rv, input logic [31:0] rd);
    io_req_valid                 = v;
    io_mem_req_ready             = mrdy;
    io_mem_rsp_valid             = rv;
    io_mem_rsp_bits_dataResponse = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // ch0: addr 0x10 write, ch1: addr 0x20 read
    io_req_bits_addrRequest    = {32'h0000_0020, 32'h0000_0010};
    io_req_bits_dataRequest    = {32'h0000_00D1, 32'h0000_00D0};
    io_req_bits_activeByteLane = {4'h3, 4'hF};
    io_req_bits_isWrite        = 2'b01;

    // Reset behaviour
    reset = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check_eq("rst_mem_valid", io_mem_req_valid, 64'd0);
    check_eq("rst_req_ready", io_req_ready, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("rst_outstanding", io_outstanding, 64'd0);
    check_eq("rst_err", io_err_unexpected_rsp, 64'd0);
    check_eq("rst_rsp_valid", io_rsp_valid, 64'd0);

    // Both channels valid, memory always ready, 1-cycle responses
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, (i > 0), 32'h100 + i);
      check_eq($sformatf("a_ready%0d", i), io_req_ready, (i % 2 == 0) ? 64'd1 : 64'd2);
      check_eq($sformatf("a_addr%0d", i), io_mem_req_bits_addrRequest,
               (i % 2 == 0) ? 64'h10 : 64'h20);
      if (i > 0) begin
        check_eq($sformatf("a_rsp%0d", i), io_rsp_valid, ((i - 1) % 2 == 0) ? 64'd1 : 64'd2);
        check_eq($sformatf("a_rdata%0d", i), io_rsp_bits_dataResponse, 64'h100 + i);
        check_eq($sformatf("a_outst%0d", i), io_outstanding, 64'd1);
      end else begin
        check_eq("a_rsp0", io_rsp_valid, 64'd0);
      end
      tick();
    end
    drive(2'b00, 1'b1, 1'b1, 32'h200);
    check_eq("a_drain", io_rsp_valid, 64'd2);
    tick();
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("a_empty", io_outstanding, 64'd0);

    // Lock: ch1 stalled 3 cycles, ch0 arrives in cycle 2
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    check_eq("b_c1_valid", io_mem_req_valid, 64'd1);
    check_eq("b_c1_addr", io_mem_req_bits_addrRequest, 64'h20);
    check_eq("b_c1_ready", io_req_ready, 64'd0);
    tick();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    check_eq("b_c2_addr", io_mem_req_bits_addrRequest, 64'h20);
    check_eq("b_c2_ready", io_req_ready, 64'd0);
    tick();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    check_eq("b_c3_addr", io_mem_req_bits_addrRequest, 64'h20);
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check_eq("b_c4_ready", io_req_ready, 64'd2);
    tick();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    check_eq("b_c5_ready", io_req_ready, 64'd1);
    tick();
    drive(2'b00, 1'b1, 1'b1, 32'h0);
    check_eq("b_rsp1", io_rsp_valid, 64'd2);
    tick();
    drive(2'b00, 1'b1, 1'b1, 32'h0);
    check_eq("b_rsp0", io_rsp_valid, 64'd1);
    tick();
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("b_empty", io_outstanding, 64'd0);

    // FIFO full: pointer now at 1, responses withheld
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      check_eq($sformatf("c_ready%0d", i), io_req_ready, (i % 2 == 0) ? 64'd2 : 64'd1);
      check_eq($sformatf("c_outst%0d", i), io_outstanding, 64'(i));
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check_eq("c_full_valid", io_mem_req_valid, 64'd0);
    check_eq("c_full_ready", io_req_ready, 64'd0);
    check_eq("c_full_outst", io_outstanding, 64'd4);
    tick();
    drive(2'b11, 1'b1, 1'b1, 32'h55);
    check_eq("c_bubble_valid", io_mem_req_valid, 64'd0);
    check_eq("c_bubble_rsp", io_rsp_valid, 64'd2);
    tick();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check_eq("c_resume_ready", io_req_ready, 64'd2);
    check_eq("c_resume_outst", io_outstanding, 64'd3);
    tick();
    for (int j = 0; j < 4; j++) begin
      drive(2'b00, 1'b1, 1'b1, 32'h0);
      check_eq($sformatf("c_drain%0d", j), io_rsp_valid, (j % 2 == 0) ? 64'd1 : 64'd2);
      tick();
    end
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("c_empty", io_outstanding, 64'd0);

    // Interleaved responses routed in order
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    check_eq("d_ready0", io_req_ready, 64'd1);
    check_eq("d_addr0", io_mem_req_bits_addrRequest, 64'h10);
    tick();
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    check_eq("d_ready1", io_req_ready, 64'd2);
    check_eq("d_addr1", io_mem_req_bits_addrRequest, 64'h20);
    tick();
    drive(2'b00, 1'b1, 1'b1, 32'hAAAA);
    check_eq("d_rsp0", io_rsp_valid, 64'd1);
    check_eq("d_data0", io_rsp_bits_dataResponse, 64'hAAAA);
    tick();
    drive(2'b00, 1'b1, 1'b1, 32'hBBBB);
    check_eq("d_rsp1", io_rsp_valid, 64'd2);
    check_eq("d_data1", io_rsp_bits_dataResponse, 64'hBBBB);
    tick();

    // Unexpected response after reset
    reset = 1'b1;
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    drive(2'b00, 1'b1, 1'b1, 32'h0);
    check_eq("e_rsp_valid", io_rsp_valid, 64'd0);
    check_eq("e_err_before", io_err_unexpected_rsp, 64'd0);
    tick();
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("e_err_set", io_err_unexpected_rsp, 64'd1);
    tick();
    tick();
    check_eq("e_err_sticky", io_err_unexpected_rsp, 64'd1);
    check_eq("e_rsp_idle", io_rsp_valid, 64'd0);

    // Reset with 3 outstanding
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("f_outst3", io_outstanding, 64'd3);
    reset = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check_eq("f_rst_valid", io_mem_req_valid, 64'd0);
    check_eq("f_rst_ready", io_req_ready, 64'd0);
    tick();
    reset = 1'b0;
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("f_outst0", io_outstanding, 64'd0);
    check_eq("f_err_clr", io_err_unexpected_rsp, 64'd0);
    drive(2'b00, 1'b1, 1'b1, 32'h0);
    check_eq("f_rsp_valid", io_rsp_valid, 64'd0);
    tick();
    drive(2'b00, 1'b1, 1'b0, 32'h0);
    check_eq("f_err_set", io_err_unexpected_rsp, 64'd1);
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    check_eq("f_ptr0", io_req_ready, 64'd1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels, 2..8.
REQ-002 Parameter ADDR_W, default 32: request address width.
REQ-003 Parameter DATA_W, default 32: data width; byte-lane width is DATA_W/8.
REQ-004 Parameter MAX_OUTST, default 4: maximum accepted-but-unanswered requests, power of two, at least 2.
REQ-005 Clock and reset SHALL be as follows: one clock; reset is synchronous and active-high.
REQ-006 clock  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 io_req_valid  input  NUM_CH  per-channel request valid.
REQ-009 io_req_ready  output  NUM_CH  per-channel request accepted this cycle.
REQ-010 io_req_bits_addrRequest / _dataRequest / _activeByteLane / _isWrite  input  NUM_CH x (ADDR_W / DATA_W / DATA_W/8 / 1)  per-channel request payload.
REQ-011 io_rsp_valid  output  NUM_CH  per-channel response valid, one-hot or zero.
REQ-012 io_rsp_bits_dataResponse  output  DATA_W  response data, shared by all channels.
REQ-013 io_mem_req_valid, io_mem_req_bits_*  output  1, ADDR_W, DATA_W, DATA_W/8, 1  downstream memory request.
REQ-014 io_mem_req_ready  input  1  memory accepts the request; tie to 1 for an always-ready SRAM.
REQ-015 io_mem_rsp_valid, io_mem_rsp_bits_dataResponse  input  1, DATA_W  downstream response.
REQ-016 io_outstanding  output  clog2(MAX_OUTST)+1  current outstanding count.
REQ-017 io_err_unexpected_rsp  output  1  sticky error flag.

Function
REQ-018 Arbitration SHALL be round-robin: the grant goes to the first valid channel at or after the priority pointer, wrapping modulo NUM_CH.
REQ-019 After each accepted request, the pointer SHALL move to (granted+1) mod NUM_CH; otherwise it SHALL hold.
REQ-020 io_mem_req_valid SHALL equal (any io_req_valid) AND NOT fifo_full, where the granted channel's payload drives io_mem_req_bits_*.
REQ-021 A request is accepted when io_mem_req_valid && io_mem_req_ready; io_req_ready[g] SHALL be 1 only in that cycle, and only for the granted channel g.
REQ-022 Lock: while io_mem_req_valid=1 and io_mem_req_ready=0, the grant SHALL be registered and held on the same channel until acceptance, even if a higher-priority channel becomes valid.
REQ-023 Requesters SHALL hold valid and payload until ready; the lock SHALL clear if the locked channel drops valid (protocol violation, no error flag).
REQ-024 Every accepted request, read or write, yields exactly one in-order memory response; on acceptance the granted channel ID SHALL be pushed into the ID FIFO (depth MAX_OUTST).
REQ-025 On io_mem_rsp_valid with the FIFO non-empty: pop the head, and in the same cycle (combinational, zero added latency) set io_rsp_valid[head]=1 and drive the data through.
REQ-026 Full FIFO: no acceptance, even if a pop occurs the same cycle (one-cycle bubble is accepted).
REQ-027 Empty FIFO with io_mem_rsp_valid: discard the response, drive io_rsp_valid to zero, set io_err_unexpected_rsp=1 until reset; a same-cycle push does not match this response.
REQ-028 Simultaneous push and pop when non-empty and non-full SHALL leave the count unchanged; FIFO pointers wrap modulo MAX_OUTST.

Reset
REQ-029 Reset SHALL clear the pointer to 0, the lock, the FIFO (count 0) and the error flag.
REQ-030 While reset is asserted and after it: io_req_ready=0, io_mem_req_valid=0 (during reset), io_rsp_valid=0, io_outstanding=0.
REQ-031 Reset mid-operation SHALL drop all outstanding IDs; memory-side state is the integrator's concern.

Structure
REQ-032 Shared package mem_arb_pkg SHALL hold the request payload struct (addr, data, byte-lane, isWrite) parameterised via localparams, and the clog2 helper constants.
REQ-033 The ID FIFO SHALL be a sub-module id_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty/count.

Verification
REQ-034 NUM_CH=2, both channels valid continuously, mem always ready: grants alternate 0,1,0,1; io_outstanding reaches 1 with 1-cycle SRAM responses.
REQ-035 Channel 1 valid, io_mem_req_ready=0 for 3 cycles, channel 0 raised in cycle 2: grant stays on 1 and is accepted in cycle 4; channel 0 is accepted next.
REQ-036 MAX_OUTST=4, memory withholds responses: 4 acceptances, then io_mem_req_valid=0; one response -> exactly one cycle with no acceptance, then acceptance resumes.
REQ-037 Interleave channel 0 addr 0x10 and channel 1 addr 0x20, with responses 0xAAAA then 0xBBBB: io_rsp_valid[0] carries 0xAAAA, then io_rsp_valid[1] carries 0xBBBB.
REQ-038 io_mem_rsp_valid pulsed after reset with no request: io_err_unexpected_rsp=1 and stays set; io_rsp_valid stays 0.
REQ-039 Reset asserted with 3 outstanding: next cycle io_outstanding=0 and the pointer is 0; a following response sets the error flag.
